x25519_ladder_sequencer: RTL and testbench

Sequencer for the X25519 Montgomery ladder. It accepts a scalar and a base-point u-coordinate, clamps the scalar, and drives the single-iteration datapath (`X25519_MainLoopIteration`) once per scalar bit, 255 times, from bit 254 down to bit 0. Each iteration's (x,z) pair outputs are fed back as the next iteration's inputs, and the final projective pair is presented with a done pulse. It sits between the crypto command front-end and the iteration datapath and owns all loop control, bit selection and watchdog handling.

---
 rtl/x25519_ladder_sequencer.sv | 132 +++++++++++++
 tb/tb_x25519_ladder_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/x25519_ladder_sequencer.sv
// Loop controller for the X25519 Montgomery ladder: clamps the scalar, issues one
// datapath iteration per scalar bit from NUM_ITERS-1 down to 0, and guards each with a watchdog.
module x25519_ladder_sequencer #(
  parameter int unsigned NUM_ITERS      = 255,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] scalar,
  input  logic [255:0] u_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [511:0] result_xzm,
  output logic         iter_en,
  output logic [511:0] iter_xzm,
  output logic [511:0] iter_xzm1,
  output logic [263:0] iter_work_low,
  output logic         iter_b,
  input  logic         iter_out_valid,
  input  logic [511:0] iter_xzm_out,
  input  logic [511:0] iter_xzm1_out
);

  localparam int unsigned IW = $clog2(NUM_ITERS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ITERS - 1);
  localparam logic [TW-1:0] WD_LIMIT = TW'(TIMEOUT_CYCLES - 1);

  // Clamp: clear bits [2:0] and 255, force bit 254.
  localparam logic [255:0] CLAMP_KEEP = {2'b00, {251{1'b1}}, 3'b000};
  localparam logic [255:0] CLAMP_SET  = {2'b01, 254'd0};

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t          state;
  logic [255:0]    k;
  logic [IW-1:0]   idx;
  logic [TW-1:0]   wd;
  logic            err_flag;
  logic [255:0]    k_clamped;
  logic [IW-1:0]   idx_dec;

  always_comb begin
    k_clamped = (scalar & CLAMP_KEEP) | CLAMP_SET;
    idx_dec   = idx - IW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      k             <= '0;
      idx           <= '0;
      wd            <= '0;
      err_flag      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      result_xzm    <= '0;
      iter_en       <= 1'b0;
      iter_xzm      <= '0;
      iter_xzm1     <= '0;
      iter_work_low <= '0;
      iter_b        <= 1'b0;
    end else begin
      iter_en <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          // A strobe while idle is charged to the next operation.
          if (iter_out_valid) err_flag <= 1'b1;
          if (start) begin
            k             <= k_clamped;
            iter_work_low <= {8'h00, u_in};
            iter_xzm      <= {256'd0, 256'd1};
            iter_xzm1     <= {256'd1, u_in};
            idx           <= LAST_IDX;
            iter_b        <= k_clamped[LAST_IDX];
            iter_en       <= 1'b1;
            busy          <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (iter_out_valid) err_flag <= 1'b1;
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A result on the expiry cycle still wins over the timeout.
          if (iter_out_valid) begin
            iter_xzm  <= iter_xzm_out;
            iter_xzm1 <= iter_xzm1_out;
            if (idx == '0) begin
              result_xzm <= iter_xzm_out;
              done       <= 1'b1;
              err        <= err_flag;
              state      <= DONE;
            end else begin
              idx     <= idx_dec;
              iter_b  <= k[idx_dec];
              iter_en <= 1'b1;
              state   <= ISSUE;
            end
          end else if (wd == WD_LIMIT) begin
            done     <= 1'b1;
            err      <= 1'b1;
            err_flag <= 1'b1;
            state    <= DONE;
          end else begin
            wd <= wd + TW'(1);
          end
        end
        DONE: begin
          // Flag is cleared, but a stray strobe landing here carries into the next operation.
          err_flag <= iter_out_valid;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_x25519_ladder_sequencer.sv
// Bench for x25519_ladder_sequencer: a latency-programmable stub datapath plus a
// reference model of the clamped bit sequence, operand chain and cycle timing.
module tb_x25519_ladder_sequencer;

  localparam int NUM = 255;
  localparam int TMO = 15;
  localparam logic [511:0] INIT_M = {256'd0, 256'd1};

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [255:0] scalar = '0;
  logic [255:0] u_in = '0;
  logic         busy, done, err, iter_en, iter_b;
  logic [511:0] result_xzm, iter_xzm, iter_xzm1;
  logic [263:0] iter_work_low;
  logic         iter_out_valid = 1'b0;
  logic [511:0] iter_xzm_out = '0;
  logic [511:0] iter_xzm1_out = '0;

  x25519_ladder_sequencer #(.NUM_ITERS(NUM), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .scalar(scalar), .u_in(u_in),
    .busy(busy), .done(done), .err(err), .result_xzm(result_xzm),
    .iter_en(iter_en), .iter_xzm(iter_xzm), .iter_xzm1(iter_xzm1),
    .iter_work_low(iter_work_low), .iter_b(iter_b),
    .iter_out_valid(iter_out_valid), .iter_xzm_out(iter_xzm_out),
    .iter_xzm1_out(iter_xzm1_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Stub datapath controls and observation queues
  bit           stub_on = 1'b0;
  bit           stray_req = 1'b0;
  bit           stray_on_en = 1'b0;
  int           lat = 3;
  int unsigned  dm = 1, dm1 = 2;
  bit           pend_valid = 1'b0;
  int           pend_due = 0;
  logic [511:0] pend_m, pend_m1;
  int           mon_t[$];
  logic         mon_b[$];
  logic [511:0] mon_m[$];
  logic [511:0] mon_m1[$];
  logic [263:0] mon_wl[$];

  initial begin
    forever begin
      @(negedge clk);
      iter_out_valid = 1'b0;
      if (stray_req) begin
        iter_out_valid = 1'b1;
        iter_xzm_out   = {16{32'hdeadbeef}};
        iter_xzm1_out  = {16{32'hbadc0ffe}};
        stray_req      = 1'b0;
      end else if (stub_on && pend_valid && cyc == pend_due) begin
        iter_out_valid = 1'b1;
        iter_xzm_out   = pend_m;
        iter_xzm1_out  = pend_m1;
        pend_valid     = 1'b0;
      end
      if (iter_en) begin
        mon_t.push_back(cyc);
        mon_b.push_back(iter_b);
        mon_m.push_back(iter_xzm);
        mon_m1.push_back(iter_xzm1);
        mon_wl.push_back(iter_work_low);
        if (stray_on_en) begin
          iter_out_valid = 1'b1;
          iter_xzm_out   = {16{32'h0badf00d}};
          iter_xzm1_out  = {16{32'h0badf00d}};
          stray_on_en    = 1'b0;
        end
        if (stub_on) begin
          pend_valid = 1'b1;
          pend_due   = cyc + lat;
          pend_m     = iter_xzm + 512'(dm);
          pend_m1    = iter_xzm1 + 512'(dm1);
        end
      end
    end
  end

  // Reference model: clamping by arithmetic on the scalar value
  function automatic logic [255:0] clamp_model(input logic [255:0] s);
    logic [255:0] kk;
    kk = s - (s % 256'd8);
    if (kk >= (256'd1 << 255)) kk = kk - (256'd1 << 255);
    if (kk < (256'd1 << 254)) kk = kk + (256'd1 << 254);
    return kk;
  endfunction

  function automatic logic exp_bit(input logic [255:0] kk, input int i);
    logic [255:0] sh;
    sh = (kk >> (NUM - 1 - i)) % 256'd2;
    return sh[0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  typedef struct {
    logic [255:0] scalar;
    logic [255:0] u;
    int           lat;
    int unsigned  dm;
    int unsigned  dm1;
    int           restart_at;
    bit           stray_on_en;
    bit           exp_err;
    logic [511:0] exp_result;
    int           exp_done;
  } vec_t;

  function automatic vec_t mkvec(input logic [255:0] s, input logic [255:0] u, input int l,
                                 input int unsigned d0, input int unsigned d1, input int rs,
                                 input bit st, input bit ee);
    vec_t v;
    v.scalar = s; v.u = u; v.lat = l; v.dm = d0; v.dm1 = d1;
    v.restart_at = rs; v.stray_on_en = st; v.exp_err = ee;
    v.exp_result = INIT_M + 512'(NUM) * 512'(d0);
    v.exp_done = NUM * (l + 1) + 1;
    return v;
  endfunction

  task automatic run_op(input vec_t v, input string tag);
    int s, d, bad;
    logic e, b, dn;
    logic [511:0] r;
    logic [255:0] kk;
    @(negedge clk);
    mon_t.delete(); mon_b.delete(); mon_m.delete(); mon_m1.delete(); mon_wl.delete();
    pend_valid = 1'b0;
    lat = v.lat; dm = v.dm; dm1 = v.dm1;
    stub_on = 1'b1;
    stray_on_en = v.stray_on_en;
    scalar = v.scalar; u_in = v.u; start = 1'b1; s = cyc;
    @(negedge clk);
    start = 1'b0; scalar = ~v.scalar; u_in = ~v.u;
    d = -1; e = 1'bx; b = 1'bx; r = 'x;
    for (int n = 1; n <= v.exp_done + 200; n++) begin
      start = (n == v.restart_at);
      if (done) begin
        d = cyc - s; e = err; b = busy; r = result_xzm;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check($sformatf("%s.done_at", tag), 512'(d), 512'(v.exp_done));
    check($sformatf("%s.err", tag), 512'(e), 512'(v.exp_err));
    check($sformatf("%s.busy_in_done", tag), 512'(b), 512'(1));
    check($sformatf("%s.result", tag), r, v.exp_result);
    check($sformatf("%s.en_count", tag), 512'(mon_t.size()), 512'(NUM));
    if (mon_t.size() > 0) begin
      kk = clamp_model(v.scalar);
      check($sformatf("%s.first_en", tag), 512'(mon_t[0] - s), 512'(1));
      check($sformatf("%s.work_low", tag), 512'(mon_wl[0]), {248'd0, 8'h00, v.u});
      bad = 0;
      for (int i = 0; i < mon_b.size(); i++)
        if (mon_b[i] !== exp_bit(kk, i)) begin bad = i; break; end
      check($sformatf("%s.iter_b[%0d]", tag, bad), 512'(mon_b[bad]), 512'(exp_bit(kk, bad)));
      bad = 0;
      for (int i = 0; i < mon_m.size(); i++)
        if (mon_m[i] !== INIT_M + 512'(i) * 512'(v.dm)) begin bad = i; break; end
      check($sformatf("%s.iter_xzm[%0d]", tag, bad), mon_m[bad], INIT_M + 512'(bad) * 512'(v.dm));
      bad = 0;
      for (int i = 0; i < mon_m1.size(); i++)
        if (mon_m1[i] !== {256'd1, v.u} + 512'(i) * 512'(v.dm1)) begin bad = i; break; end
      check($sformatf("%s.iter_xzm1[%0d]", tag, bad), mon_m1[bad],
            {256'd1, v.u} + 512'(bad) * 512'(v.dm1));
    end
    if (mon_t.size() > 1) begin
      bad = 1;
      for (int i = 1; i < mon_t.size(); i++)
        if (mon_t[i] - mon_t[i-1] != v.lat + 1) begin bad = i; break; end
      check($sformatf("%s.period", tag), 512'(mon_t[bad] - mon_t[bad-1]), 512'(v.lat + 1));
    end
    @(negedge clk);
    dn = done;
    check($sformatf("%s.busy_after", tag), 512'(busy), 512'(0));
    check($sformatf("%s.done_pulse", tag), 512'(dn), 512'(0));
  endtask

  vec_t vecs[10];

  initial begin : main
    int s, d;
    logic e;
    vecs[0] = mkvec('1, 256'd9, 3, 1, 2, 0, 1'b0, 1'b0);
    vecs[1] = mkvec(256'd1 << 255, rand256(), 3, 1, 2, 0, 1'b0, 1'b0);
    vecs[2] = mkvec('1, 256'd9, 3, 1, 2, 50, 1'b0, 1'b0);
    vecs[3] = mkvec(rand256(), rand256(), 3, 1, 2, 0, 1'b1, 1'b1);
    vecs[4] = mkvec(rand256(), rand256(), TMO, $urandom(), $urandom(), 0, 1'b0, 1'b0);
    vecs[5] = mkvec(rand256(), rand256(), 1, $urandom(), $urandom(), 0, 1'b0, 1'b0);
    for (int i = 6; i < 10; i++)
      vecs[i] = mkvec(rand256(), rand256(), int'($urandom_range(1, 8)), $urandom(), $urandom(),
                      0, 1'b0, 1'b0);

    #1 rst_n = 1'b0;
    #1;
    check("reset_state", {busy, done, err, iter_en, iter_b, |iter_xzm, |iter_xzm1,
                          |iter_work_low, |result_xzm}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Watchdog: stub never answers
    @(negedge clk);
    mon_t.delete(); mon_b.delete(); mon_m.delete(); mon_m1.delete(); mon_wl.delete();
    stub_on = 1'b0; pend_valid = 1'b0;
    scalar = rand256(); u_in = rand256(); start = 1'b1; s = cyc;
    @(negedge clk);
    start = 1'b0;
    d = -1; e = 1'bx;
    for (int n = 1; n < 200; n++) begin
      if (done) begin d = cyc - s; e = err; break; end
      @(negedge clk);
    end
    check("timeout.done_at", 512'(d), 512'(TMO + 2));
    check("timeout.err", 512'(e), 512'(1));
    check("timeout.en_count", 512'(mon_t.size()), 512'(1));
    @(negedge clk);
    check("timeout.busy_after", 512'(busy), 512'(0));

    // Reset mid-operation, then a late datapath response while idle
    @(negedge clk);
    pend_valid = 1'b0; lat = 3; dm = 1; dm1 = 2; stub_on = 1'b1;
    scalar = '1; u_in = 256'd9; start = 1'b1; s = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 200) @(negedge clk);
    #2 rst_n = 1'b0; stub_on = 1'b0;
    #1;
    check("reset_mid_op", {busy, done, err, iter_en, iter_b, |iter_xzm, |iter_xzm1,
                           |iter_work_low, |result_xzm}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 stray_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    run_op(mkvec(rand256(), rand256(), 2, 3, 5, 0, 1'b0, 1'b1), "after_reset");
    run_op(mkvec(rand256(), rand256(), 2, 3, 5, 0, 1'b0, 1'b0), "flag_cleared");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "bench time limit");
  end

endmodule
